flex_bit_timer: RTL and testbench
=================================

# flex_bit_timer

Parametrised bit/packet timer for serial receive paths. It generates one `shift_strobe` per bit at a programmable mid-bit sample point and a `packet_done` pulse after a programmable bit count. Clocks-per-bit, sample offset and packet length are runtime inputs latched at packet start. It sits between the start-bit detector and the receive shift register, feeding strobes to the shift register and `packet_done` to the receive controller.

## Interface
- `CLK_BITS`, 8: width of the clocks-per-bit counter and its config inputs.
- `BIT_BITS`, 4: width of the bit counter and its config/status.
- `ABORT_ON_DROP`, 1: 1 = `enable_timer` low during a packet aborts it; 0 = it pauses counting.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high; the only clock and reset.
- `enable_timer` in 1: a rising edge starts a packet; level gates counting.
- `clks_per_bit` in CLK_BITS: bit period P in clocks.
- `sample_offset` in CLK_BITS: clocks from start to the first strobe, O.
- `bits_per_packet` in BIT_BITS: strobes per packet, B.
- `shift_strobe` out 1: one-cycle pulse per bit.
- `packet_done` out 1: one-cycle pulse after the last strobe.
- `packet_abort` out 1: one-cycle pulse when a packet is aborted.
- `busy` out 1: a packet is in progress.
- `bit_index` out BIT_BITS: strobes issued in the current packet.

## Operation
- States: IDLE, RUN, DONE.
- A registered `en_d` holds `enable_timer` from the previous cycle.
- Start edge: a clock edge in IDLE with `enable_timer`=1 and `en_d`=0.
- At the start edge:
  - Latch the config with clamps: P<2 becomes 2; B=0 becomes 1; O=0 becomes 1; O>P becomes P.
  - Clear the clock counter to 0 and `bit_index` to 0; enter RUN.
- Config changes during RUN or DONE are ignored.
- RUN, on an edge with `enable_timer`=1:
  - Increment the clock counter.
  - On reaching the target (O for the first bit, P for later bits), assert `shift_strobe` for the next cycle, increment `bit_index` and clear the clock counter.
  - When the B-th strobe is issued, enter DONE.
- RUN, on an edge with `enable_timer`=0:
  - ABORT_ON_DROP=1: enter IDLE, pulse `packet_abort`, clear `bit_index`, no `packet_done`.
  - ABORT_ON_DROP=0: counters freeze and no strobe is issued; counting resumes when enable returns high, with no restart.
- DONE: assert `packet_done` for one cycle, then enter IDLE.
- A new packet needs a fresh rising edge; `enable_timer` held high after DONE does not retrigger.
- Simultaneous events: if enable drops on the edge where a strobe would fire, no strobe fires (abort or pause wins).

## Timing
- All outputs are registered. Edge n means the n-th rising edge after the start edge (the start edge is edge 0).
- `shift_strobe` is high in the cycle following edges O, O+P, …, O+(B−1)P, assuming no pause.
- `packet_done` is high in the cycle following edge O+(B−1)P+1.
- `busy` rises after edge 0 and falls after edge O+(B−1)P+2.
- `bit_index` updates in the same cycle as each strobe and holds B through DONE. It clears at the next start edge or on abort.
- Pause extends every later event by the number of cycles enable is low.
- `packet_abort` is high in the cycle after the edge that samples enable low.
- Reset values: all outputs 0, state IDLE, counters 0, `en_d`=1. So `enable_timer` held high through reset does not start a packet.
- Reset mid-packet: outputs 0 in the cycle after the reset edge; no `packet_done` or `packet_abort` is emitted.

## Structure
- Package `bit_timer_pkg`:
  - state enum `bt_state_t` (IDLE, RUN, DONE);
  - constants `BT_MIN_CLKS_PER_BIT`=2, `BT_MIN_BITS`=1, `BT_MIN_OFFSET`=1.
- Sub-module `sync_flex_counter`:
  - parametrised width; ports `clear`, `count_enable`, `rollover_val`, `count`, `rollover_flag`;
  - synchronous active-high reset.
- One instance is the clock counter (its rollover value muxes between O and P); a second instance is the bit counter.
- The FSM and config-clamp registers live in `flex_bit_timer`.

## Test plan
- P=10, O=5, B=9, enable raised and held: strobes after edges 5, 15, …, 85; `packet_done` after edge 86; `busy` low after edge 87; `bit_index` ends at 9.
- Clamps: P=0, O=0, B=0 → one strobe after edge 1, `packet_done` after edge 2. O=20, P=10 → first strobe after edge 10.
- ABORT_ON_DROP=1, P=10, O=5, B=9, enable dropped at edge 30 → strobes after edges 5, 15 and 25 only; `packet_abort` after edge 30; `busy` 0; no `packet_done`.
- ABORT_ON_DROP=0, same config, enable low for 3 cycles starting at edge 12 → later strobes shift by 3 (18, 28, …); `packet_done` after edge 89.
- Enable held high after `packet_done` → no second packet; toggling it low then high starts a new packet using new config values.
- `rst` asserted at edge 40 with enable held high → outputs 0 next cycle; no start after reset release until enable falls and rises again.

Source files
------------

// File: rtl/bit_timer_pkg.sv
// Shared types and clamp limits for the flex bit timer.
package bit_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bt_state_t;

    localparam int unsigned BT_MIN_CLKS_PER_BIT = 2;
    localparam int unsigned BT_MIN_BITS         = 1;
    localparam int unsigned BT_MIN_OFFSET       = 1;

endpackage

// File: rtl/sync_flex_counter.sv
// Up-counter that wraps to zero on the increment that would reach rollover_val.
module sync_flex_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count,
    output logic             rollover_flag
);

    localparam int unsigned NEXT_W = WIDTH + 1;

    logic [WIDTH-1:0]  r_count;
    logic [NEXT_W-1:0] w_next;

    // One extra bit so rollover_val at full scale still compares correctly
    assign w_next        = {1'b0, r_count} + NEXT_W'(1);
    // Lookahead: the next enabled increment lands on rollover_val (combinational)
    assign rollover_flag = (w_next == {1'b0, rollover_val});
    assign count         = r_count;

    // Count register; clear has priority over counting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            if (rollover_flag) begin
                r_count <= '0;
            end else begin
                r_count <= w_next[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/flex_bit_timer.sv
// Bit/packet timer: mid-bit shift strobes and end-of-packet pulse for a serial receiver.
module flex_bit_timer
    import bit_timer_pkg::*;
#(
    parameter int unsigned CLK_BITS      = 8,
    parameter int unsigned BIT_BITS      = 4,
    parameter bit          ABORT_ON_DROP = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_timer,
    input  logic [CLK_BITS-1:0] clks_per_bit,
    input  logic [CLK_BITS-1:0] sample_offset,
    input  logic [BIT_BITS-1:0] bits_per_packet,
    output logic                shift_strobe,
    output logic                packet_done,
    output logic                packet_abort,
    output logic                busy,
    output logic [BIT_BITS-1:0] bit_index
);

    bt_state_t           r_state;
    logic                r_en_d;
    logic [CLK_BITS-1:0] r_period;
    logic [CLK_BITS-1:0] r_offset;
    logic [BIT_BITS-1:0] r_bits;
    logic [BIT_BITS-1:0] r_bit_index;
    logic                r_shift_strobe;
    logic                r_packet_done;
    logic                r_packet_abort;
    logic                r_busy;

    logic [CLK_BITS-1:0] w_period;
    logic [CLK_BITS-1:0] w_offset;
    logic [BIT_BITS-1:0] w_bits;
    logic [CLK_BITS-1:0] w_clk_target;
    logic [CLK_BITS-1:0] w_clk_count;
    logic [BIT_BITS-1:0] w_bit_count;
    logic                w_clk_roll;
    logic                w_bit_roll;
    logic                w_start;
    logic                w_run_en;
    logic                w_abort;
    logic                w_strobe;
    logic                w_cnt_clear;

    assign w_start     = (r_state == IDLE) && enable_timer && !r_en_d;
    assign w_run_en    = (r_state == RUN) && enable_timer;
    assign w_abort     = (r_state == RUN) && !enable_timer && ABORT_ON_DROP;
    assign w_strobe    = w_run_en && w_clk_roll;
    assign w_cnt_clear = w_start || w_abort;

    // First bit times from the start edge to the offset, later bits a full period
    assign w_clk_target = (w_bit_count == '0) ? r_offset : r_period;

    assign w_period = (clks_per_bit < CLK_BITS'(BT_MIN_CLKS_PER_BIT))
                      ? CLK_BITS'(BT_MIN_CLKS_PER_BIT) : clks_per_bit;
    assign w_bits   = (bits_per_packet < BIT_BITS'(BT_MIN_BITS))
                      ? BIT_BITS'(BT_MIN_BITS) : bits_per_packet;

    // Offset clamp uses the already-clamped period as its ceiling
    always_comb begin
        w_offset = sample_offset;
        if (w_offset < CLK_BITS'(BT_MIN_OFFSET)) begin
            w_offset = CLK_BITS'(BT_MIN_OFFSET);
        end
        if (w_offset > w_period) begin
            w_offset = w_period;
        end
    end

    sync_flex_counter #(
        .WIDTH (CLK_BITS)
    ) u_clk_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear         (w_cnt_clear),
        .count_enable  (w_run_en),
        .rollover_val  (w_clk_target),
        .count         (w_clk_count),
        .rollover_flag (w_clk_roll)
    );

    sync_flex_counter #(
        .WIDTH (BIT_BITS)
    ) u_bit_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear         (w_cnt_clear),
        .count_enable  (w_strobe),
        .rollover_val  (r_bits),
        .count         (w_bit_count),
        .rollover_flag (w_bit_roll)
    );

    // Packet FSM with config latching and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_en_d         <= 1'b1;
            r_period       <= '0;
            r_offset       <= '0;
            r_bits         <= '0;
            r_bit_index    <= '0;
            r_shift_strobe <= 1'b0;
            r_packet_done  <= 1'b0;
            r_packet_abort <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_en_d         <= enable_timer;
            r_shift_strobe <= 1'b0;
            r_packet_done  <= 1'b0;
            r_packet_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (w_start) begin
                        r_period    <= w_period;
                        r_offset    <= w_offset;
                        r_bits      <= w_bits;
                        r_bit_index <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    if (w_strobe) begin
                        r_shift_strobe <= 1'b1;
                        r_bit_index    <= r_bit_index + BIT_BITS'(1);
                        if (w_bit_roll) begin
                            r_state <= DONE;
                        end
                    end else if (w_abort) begin
                        r_state        <= IDLE;
                        r_packet_abort <= 1'b1;
                        r_bit_index    <= '0;
                        r_busy         <= 1'b0;
                    end
                end
                DONE: begin
                    r_packet_done <= 1'b1;
                    r_state       <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // While running, the clock count never reaches the active target
    assert property (@(posedge clk) disable iff (rst)
                     (r_state == RUN) |-> (w_clk_count < w_clk_target));

    assign shift_strobe = r_shift_strobe;
    assign packet_done  = r_packet_done;
    assign packet_abort = r_packet_abort;
    assign busy         = r_busy;
    assign bit_index    = r_bit_index;

endmodule

// File: tb/tb_flex_bit_timer.sv
// Self-checking bench: tables, directed corner sequences and random stimulus vs a reference model.
module tb_flex_bit_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic [7:0] cpb;
    logic [7:0] off;
    logic [3:0] bpp;

    logic       strobe_a, done_a, abort_a, busy_a;
    logic [3:0] idx_a;
    logic       strobe_p, done_p, abort_p, busy_p;
    logic [3:0] idx_p;

    int n_checks = 0;
    int n_fail   = 0;

    flex_bit_timer #(.CLK_BITS(8), .BIT_BITS(4), .ABORT_ON_DROP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .enable_timer(en),
        .clks_per_bit(cpb), .sample_offset(off), .bits_per_packet(bpp),
        .shift_strobe(strobe_a), .packet_done(done_a), .packet_abort(abort_a),
        .busy(busy_a), .bit_index(idx_a)
    );

    flex_bit_timer #(.CLK_BITS(8), .BIT_BITS(4), .ABORT_ON_DROP(1'b0)) dut_p (
        .clk(clk), .rst(rst), .enable_timer(en),
        .clks_per_bit(cpb), .sample_offset(off), .bits_per_packet(bpp),
        .shift_strobe(strobe_p), .packet_done(done_p), .packet_abort(abort_p),
        .busy(busy_p), .bit_index(idx_p)
    );

    // Reference model state; index 0 = pause variant, 1 = abort variant
    int unsigned md_phase [2];   // 0 idle, 1 counting, 2 done pending
    int unsigned md_eff   [2];   // enabled edges since the start edge
    int unsigned md_nb    [2];
    int unsigned md_p     [2];
    int unsigned md_o     [2];
    int unsigned md_b     [2];
    bit          md_en_d  [2];
    bit          ex_strobe[2];
    bit          ex_done  [2];
    bit          ex_abort [2];
    bit          ex_busy  [2];
    int unsigned ex_idx   [2];

    typedef struct {
        int p; int o; int b;
        int first; int last; int done_e; int cnt; int idx;
    } vec_t;

    vec_t tbl[8];
    int   se[16];
    int   nstr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Strobe k of a packet fires on the enabled edge numbered O + k*P
    task automatic model_update();
        int unsigned vp, vo, vb;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                md_phase[m] = 0; md_en_d[m] = 1'b1; md_eff[m] = 0; md_nb[m] = 0;
                ex_strobe[m] = 0; ex_done[m] = 0; ex_abort[m] = 0; ex_busy[m] = 0; ex_idx[m] = 0;
            end else begin
                ex_strobe[m] = 0; ex_done[m] = 0; ex_abort[m] = 0;
                if (md_phase[m] == 0) begin
                    if (en && !md_en_d[m]) begin
                        vp = 32'(cpb); vo = 32'(off); vb = 32'(bpp);
                        if (vp < 2) vp = 2;
                        if (vo < 1) vo = 1;
                        if (vo > vp) vo = vp;
                        if (vb < 1) vb = 1;
                        md_p[m] = vp; md_o[m] = vo; md_b[m] = vb;
                        md_eff[m] = 0; md_nb[m] = 0; ex_idx[m] = 0;
                        ex_busy[m] = 1; md_phase[m] = 1;
                    end else begin
                        ex_busy[m] = 0;
                    end
                end else if (md_phase[m] == 1) begin
                    if (en) begin
                        md_eff[m]++;
                        if (md_eff[m] == md_o[m] + md_nb[m] * md_p[m]) begin
                            ex_strobe[m] = 1;
                            md_nb[m]++;
                            ex_idx[m] = md_nb[m];
                            if (md_nb[m] == md_b[m]) md_phase[m] = 2;
                        end
                    end else if (m == 1) begin
                        md_phase[m] = 0; ex_abort[m] = 1; ex_idx[m] = 0; ex_busy[m] = 0;
                    end
                end else begin
                    ex_done[m] = 1;
                    md_phase[m] = 0;
                end
                md_en_d[m] = en;
            end
        end
    endtask

    // Advance one clock and compare both DUTs with the model
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("cycle_pause_dut", {24'd0, strobe_p, done_p, abort_p, busy_p, idx_p},
              {24'd0, ex_strobe[0], ex_done[0], ex_abort[0], ex_busy[0], 4'(ex_idx[0])});
        check("cycle_abort_dut", {24'd0, strobe_a, done_a, abort_a, busy_a, idx_a},
              {24'd0, ex_strobe[1], ex_done[1], ex_abort[1], ex_busy[1], 4'(ex_idx[1])});
    endtask

    task automatic clear_edges();
        for (int i = 0; i < 16; i++) se[i] = -1;
        nstr = 0;
    endtask

    // Fresh rising edge, then record strobe/done edge numbers of the abort-variant DUT
    task automatic run_packet(input int p, input int o, input int b,
                              output int first, output int last, output int done_e,
                              output int cnt, output int fin_idx, output int busy_after);
        cpb = 8'(p); off = 8'(o); bpp = 4'(b);
        en = 1'b0; step(); step();
        en = 1'b1; step();
        cpb = 8'($urandom); off = 8'($urandom); bpp = 4'($urandom);
        first = -1; last = -1; done_e = -1; cnt = 0;
        for (int n = 1; n <= 400; n++) begin
            step();
            if (strobe_a) begin
                if (first < 0) first = n;
                last = n;
                cnt++;
            end
            if (done_a) begin
                done_e = n;
                break;
            end
        end
        fin_idx = 32'(idx_a);
        step();
        busy_after = 32'(busy_a);
    endtask

    int first, last, done_e, cnt, fin_idx, busy_after, ab_e, dn, quiet;
    bit done_seen;

    initial begin
        rst = 1'b1; en = 1'b0; cpb = '0; off = '0; bpp = '0;
        tbl[0] = '{10,   5,  9,   5,  85,  86,  9,  9};
        tbl[1] = '{ 0,   0,  0,   1,   1,   2,  1,  1};
        tbl[2] = '{10,  20,  2,  10,  20,  21,  2,  2};
        tbl[3] = '{ 1,   1,  3,   1,   5,   6,  3,  3};
        tbl[4] = '{ 3,   3,  4,   3,  12,  13,  4,  4};
        tbl[5] = '{255, 255, 1, 255, 255, 256,  1,  1};
        tbl[6] = '{ 4,   0, 15,   1,  57,  58, 15, 15};
        tbl[7] = '{ 2,   2,  2,   2,   4,   5,  2,  2};

        // Reset state, with enable held high through reset
        en = 1'b1;
        step(); step();
        check("reset_state_a", {24'd0, strobe_a, done_a, abort_a, busy_a, idx_a}, 32'd0);
        check("reset_state_p", {24'd0, strobe_p, done_p, abort_p, busy_p, idx_p}, 32'd0);
        rst = 1'b0;
        step(); step();
        check("no_start_after_reset", 32'(busy_a), 32'd0);

        // Table-driven packet timing
        for (int i = 0; i < 8; i++) begin
            run_packet(tbl[i].p, tbl[i].o, tbl[i].b, first, last, done_e, cnt, fin_idx, busy_after);
            check($sformatf("tbl%0d_first_strobe", i), first, tbl[i].first);
            check($sformatf("tbl%0d_last_strobe", i), last, tbl[i].last);
            check($sformatf("tbl%0d_done_edge", i), done_e, tbl[i].done_e);
            check($sformatf("tbl%0d_strobe_count", i), cnt, tbl[i].cnt);
            check($sformatf("tbl%0d_bit_index", i), fin_idx, tbl[i].idx);
            check($sformatf("tbl%0d_busy_after", i), busy_after, 32'd0);
        end

        // Abort: enable sampled low at edge 30
        rst = 1'b1; step(); rst = 1'b0; en = 1'b0; step();
        cpb = 8'd10; off = 8'd5; bpp = 4'd9; en = 1'b1; step();
        clear_edges(); ab_e = -1; done_seen = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n >= 30) en = 1'b0;
            step();
            if (strobe_a) begin
                if (nstr < 16) se[nstr] = n;
                nstr++;
            end
            if (abort_a && ab_e < 0) ab_e = n;
            if (done_a) done_seen = 1'b1;
        end
        check("abort_strobe_count", nstr, 32'd3);
        check("abort_strobe0", se[0], 32'd5);
        check("abort_strobe1", se[1], 32'd15);
        check("abort_strobe2", se[2], 32'd25);
        check("abort_edge", ab_e, 32'd30);
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_bit_index", 32'(idx_a), 32'd0);

        // Pause: enable low on edges 12..14
        rst = 1'b1; step(); rst = 1'b0; en = 1'b0; step();
        cpb = 8'd10; off = 8'd5; bpp = 4'd9; en = 1'b1; step();
        clear_edges(); dn = -1;
        for (int n = 1; n <= 100; n++) begin
            en = (n >= 12 && n <= 14) ? 1'b0 : 1'b1;
            step();
            if (strobe_p) begin
                if (nstr < 16) se[nstr] = n;
                nstr++;
            end
            if (done_p && dn < 0) dn = n;
        end
        check("pause_strobe_count", nstr, 32'd9);
        check("pause_strobe0", se[0], 32'd5);
        check("pause_strobe1", se[1], 32'd18);
        check("pause_strobe8", se[8], 32'd88);
        check("pause_done_edge", dn, 32'd89);
        check("pause_bit_index", 32'(idx_p), 32'd9);

        // Enable held high after done must not retrigger; a fresh edge uses new config
        rst = 1'b1; step(); rst = 1'b0;
        run_packet(2, 1, 1, first, last, done_e, cnt, fin_idx, busy_after);
        check("retrig_first_done", done_e, 32'd2);
        quiet = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (busy_a || busy_p || strobe_a || strobe_p) quiet++;
        end
        check("retrig_hold_no_packet", quiet, 32'd0);
        run_packet(3, 2, 2, first, last, done_e, cnt, fin_idx, busy_after);
        check("retrig_new_first", first, 32'd2);
        check("retrig_new_last", last, 32'd5);
        check("retrig_new_done", done_e, 32'd6);
        check("retrig_new_count", cnt, 32'd2);

        // Reset at edge 40 mid-packet with enable held high
        en = 1'b0; step();
        cpb = 8'd10; off = 8'd5; bpp = 4'd9; en = 1'b1; step();
        for (int n = 1; n <= 39; n++) step();
        check("rst_busy_before", 32'(busy_a), 32'd1);
        rst = 1'b1; step();
        check("rst_mid_outputs_a", {24'd0, strobe_a, done_a, abort_a, busy_a, idx_a}, 32'd0);
        check("rst_mid_outputs_p", {24'd0, strobe_p, done_p, abort_p, busy_p, idx_p}, 32'd0);
        rst = 1'b0;
        quiet = 0;
        for (int n = 0; n < 30; n++) begin
            step();
            if (busy_a || busy_p || strobe_a || strobe_p || done_a || abort_a) quiet++;
        end
        check("rst_no_restart", quiet, 32'd0);
        run_packet(10, 5, 9, first, last, done_e, cnt, fin_idx, busy_after);
        check("rst_then_packet_done", done_e, 32'd86);

        // Random enable waveform, config churn and occasional reset vs the model
        rst = 1'b1; step(); rst = 1'b0; en = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 99) < 4) en = ~en;
            if ($urandom_range(0, 99) < 20) begin
                cpb = 8'($urandom_range(0, 12));
                off = 8'($urandom_range(0, 15));
                bpp = 4'($urandom_range(0, 6));
            end
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
